// File: rtl/uart_host_link.sv
// uart_host_link: 8N1 UART link to a host with a one-byte RX holding buffer.
// Ports: in_clk/in_rst (sync, active-high) | in_uart_rx, out_uart_tx serial lines
//        data_rx/rx_done/rx_trig RX delivery handshake, out_rx_overrun, out_rx_frame_err
//        data_tx/tx_trig/tx_done/out_tx_busy TX request handshake
module uart_host_link #(
    parameter int CLK_PER_BIT = 434
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_uart_rx,
    output logic       out_uart_tx,
    output logic [7:0] data_rx,
    output logic       rx_done,
    input  logic       rx_trig,
    input  logic [7:0] data_tx,
    input  logic       tx_trig,
    output logic       tx_done,
    output logic       out_tx_busy,
    output logic       out_rx_overrun,
    output logic       out_rx_frame_err
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- RX ----------------
    logic          r_sync1, r_sync2, r_rx_prev;
    state_t        r_rx_state, w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift, r_rx_buf, r_data_rx;
    logic          r_rx_full, r_rx_armed, r_rx_done;
    logic          r_frame_err, r_overrun;
    logic          w_rx_tick, w_stop_ok, w_stop_bad, w_deliver;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= in_uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_tick = (r_rx_cnt == '0);

    always_comb begin
        w_rx_next = r_rx_state;
        unique case (r_rx_state)
            S_IDLE:  if (r_rx_prev && !r_sync2) w_rx_next = S_START;
            S_START: if (w_rx_tick) w_rx_next = r_sync2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_STOP;
            S_STOP:  if (w_rx_tick) w_rx_next = S_IDLE;
            default: w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            // IDLE preloads the half-bit wait so START samples mid start bit
            if (r_rx_state == S_IDLE) begin
                r_rx_cnt <= HALF_BIT;
                r_rx_bit <= '0;
            end else if (w_rx_tick) begin
                r_rx_cnt <= FULL_BIT;
            end else begin
                r_rx_cnt <= r_rx_cnt - CNT_ONE;
            end
            if (r_rx_state == S_DATA && w_rx_tick) begin
                r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    assign w_stop_ok  = (r_rx_state == S_STOP) && w_rx_tick && r_sync2;
    assign w_stop_bad = (r_rx_state == S_STOP) && w_rx_tick && !r_sync2;
    // a completing byte bypasses the buffer when it can be delivered at once
    assign w_deliver  = (r_rx_full || w_stop_ok) && (r_rx_armed || rx_trig);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rx_full   <= 1'b0;
            r_rx_armed  <= 1'b1;
            r_rx_done   <= 1'b0;
            r_data_rx   <= '0;
            r_rx_buf    <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_done   <= w_deliver;
            r_frame_err <= w_stop_bad;
            if (w_deliver) begin
                r_data_rx  <= r_rx_full ? r_rx_buf : r_rx_shift;
                r_rx_armed <= 1'b0;
            end else if (rx_trig) begin
                r_rx_armed <= 1'b1;
            end
            if (w_stop_ok && r_rx_full && !w_deliver)
                r_overrun <= 1'b1;
            // new byte lands in the buffer if the buffer is free after this cycle
            if (w_stop_ok && (r_rx_full ? w_deliver : !w_deliver))
                r_rx_buf <= r_rx_shift;
            r_rx_full <= r_rx_full ? (w_stop_ok || !w_deliver)
                                   : (w_stop_ok && !w_deliver);
        end
    end

    assign data_rx          = r_data_rx;
    assign rx_done          = r_rx_done;
    assign out_rx_overrun   = r_overrun;
    assign out_rx_frame_err = r_frame_err;

    // ---------------- TX ----------------
    state_t        r_tx_state, w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx_line, r_tx_done;
    logic          w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == '0);

    always_comb begin
        w_tx_next = r_tx_state;
        unique case (r_tx_state)
            S_IDLE:  if (tx_trig) w_tx_next = S_START;
            S_START: if (w_tx_tick) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
            S_STOP:  if (w_tx_tick) w_tx_next = S_IDLE;
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_done  <= (r_tx_state == S_STOP) && w_tx_tick;
            if (r_tx_state == S_IDLE) begin
                r_tx_cnt <= FULL_BIT;
                r_tx_bit <= '0;
                if (tx_trig) begin
                    r_tx_shift <= data_tx;
                    r_tx_line  <= 1'b0;
                end
            end else if (w_tx_tick) begin
                r_tx_cnt <= FULL_BIT;
                // ones shifted in behind the data become the stop bit
                if (r_tx_state != S_STOP) begin
                    r_tx_line  <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                end
                if (r_tx_state == S_DATA)
                    r_tx_bit <= r_tx_bit + 3'd1;
            end else begin
                r_tx_cnt <= r_tx_cnt - CNT_ONE;
            end
        end
    end

    assign out_uart_tx = r_tx_line;
    assign tx_done     = r_tx_done;
    assign out_tx_busy = (r_tx_state != S_IDLE);

endmodule

// File: tb/tb_uart_host_link.sv
// tb_uart_host_link: self-checking bench for uart_host_link at CLK_PER_BIT=8.
// Vector table for RX frames, frame-formula model for TX, hand sequences for corners.
module tb_uart_host_link;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       in_rst = 1'b1;
    logic       in_uart_rx = 1'b1;
    logic       out_uart_tx;
    logic [7:0] data_rx;
    logic       rx_done;
    logic       rx_trig = 1'b0;
    logic [7:0] data_tx = 8'h00;
    logic       tx_trig = 1'b0;
    logic       tx_done;
    logic       out_tx_busy;
    logic       out_rx_overrun;
    logic       out_rx_frame_err;

    uart_host_link #(.CLK_PER_BIT(CPB)) dut (
        .in_clk(clk),
        .in_rst(in_rst),
        .in_uart_rx(in_uart_rx),
        .out_uart_tx(out_uart_tx),
        .data_rx(data_rx),
        .rx_done(rx_done),
        .rx_trig(rx_trig),
        .data_tx(data_tx),
        .tx_trig(tx_trig),
        .tx_done(tx_done),
        .out_tx_busy(out_tx_busy),
        .out_rx_overrun(out_rx_overrun),
        .out_rx_frame_err(out_rx_frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ferr_n = 0;
    int txd_n = 0;
    logic [7:0] rxq[$];
    int rxc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            rxq.push_back(data_rx);
            rxc.push_back(cyc);
        end
        if (out_rx_frame_err === 1'b1) ferr_n <= ferr_n + 1;
        if (tx_done === 1'b1) txd_n <= txd_n + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // host drives one frame; returns the cycle the start bit began
    task automatic host_send(input logic [7:0] d, input logic stop, output int t0);
        t0 = cyc;
        in_uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            in_uart_rx = d[b];
            repeat (CPB) @(negedge clk);
        end
        in_uart_rx = stop;
        repeat (CPB) @(negedge clk);
        in_uart_rx = 1'b1;
    endtask

    task automatic pulse_rx_trig();
        rx_trig = 1'b1;
        @(negedge clk);
        rx_trig = 1'b0;
    endtask

    // sends one frame and checks every line cycle against the 8N1 frame formula
    task automatic send_tx(input logic [7:0] d);
        int   bad [10];
        int   k;
        logic exp_b;
        foreach (bad[j]) bad[j] = 0;
        data_tx = d;
        tx_trig = 1'b1;
        for (int i = 1; i <= 10 * CPB; i++) begin
            @(negedge clk);
            tx_trig = (i == 3 * CPB);
            data_tx = (i >= 3 * CPB) ? ~d : d;
            k = (i - 1) / CPB;
            exp_b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
            if (out_uart_tx !== exp_b || out_tx_busy !== 1'b1 || tx_done !== 1'b0)
                bad[k]++;
        end
        @(negedge clk);
        for (int j = 0; j < 10; j++)
            chk($sformatf("tx_%02h_bit%0d_badcyc", d, j), bad[j], 0);
        chk($sformatf("tx_%02h_done", d), {31'd0, tx_done}, 1);
        chk($sformatf("tx_%02h_busy_at_done", d), {31'd0, out_tx_busy}, 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       arm;
        int         exp_n;
        logic [7:0] exp_d;
        int         exp_ferr;
    } rxv_t;

    rxv_t vec [7];
    logic [7:0] expq[$];

    initial begin
        int t0, q0, f0, td0, lat, nexp, fexp;
        logic [7:0] d;
        logic       st;
        logic [9:0] fr;

        vec[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0};
        vec[1] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0};
        vec[2] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0};
        vec[3] = '{8'h3C, 1'b0, 1'b1, 0, 8'h00, 1};
        vec[4] = '{8'h81, 1'b1, 1'b1, 1, 8'h81, 0};
        vec[5] = '{8'h7E, 1'b0, 1'b0, 0, 8'h00, 1};
        vec[6] = '{8'h55, 1'b1, 1'b1, 1, 8'h55, 0};

        // reset values, during reset and in the cycle after
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, out_uart_tx}, 1);
        chk("rst_busy", {31'd0, out_tx_busy}, 0);
        chk("rst_txdone", {31'd0, tx_done}, 0);
        chk("rst_rxdone", {31'd0, rx_done}, 0);
        chk("rst_data_rx", {24'd0, data_rx}, 0);
        chk("rst_ovr", {31'd0, out_rx_overrun}, 0);
        chk("rst_ferr", {31'd0, out_rx_frame_err}, 0);
        in_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", {31'd0, out_uart_tx}, 1);
        chk("post_rst_busy", {31'd0, out_tx_busy}, 0);
        chk("post_rst_data_rx", {24'd0, data_rx}, 0);

        // RX vector table
        for (int i = 0; i < 7; i++) begin
            if (vec[i].arm) pulse_rx_trig();
            q0 = rxq.size();
            f0 = ferr_n;
            host_send(vec[i].d, vec[i].stop, t0);
            repeat (2 * CPB) @(negedge clk);
            chk($sformatf("rxv%0d_count", i), rxq.size() - q0, vec[i].exp_n);
            chk($sformatf("rxv%0d_ferr", i), ferr_n - f0, vec[i].exp_ferr);
            if (vec[i].exp_n == 1 && rxq.size() > q0) begin
                chk($sformatf("rxv%0d_data", i), {24'd0, rxq[q0]}, {24'd0, vec[i].exp_d});
                lat = rxc[q0] - t0;
                chk($sformatf("rxv%0d_lat%0d_inwin", i, lat),
                    (lat >= 9 * CPB + CPB / 2 && lat <= 10 * CPB + 2) ? 1 : 0, 1);
            end
        end
        chk("rx_no_overrun", {31'd0, out_rx_overrun}, 0);

        // 2-cycle glitch: false start, no output activity, data_rx holds
        q0 = rxq.size();
        f0 = ferr_n;
        pulse_rx_trig();
        in_uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        in_uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_count", rxq.size() - q0, 0);
        chk("glitch_ferr", ferr_n - f0, 0);
        chk("data_rx_hold", {24'd0, data_rx}, 32'h55);

        // TX framing with back-to-back second frame
        td0 = txd_n;
        send_tx(8'h3C);
        send_tx(8'hC3);
        repeat (CPB) @(negedge clk);
        chk("tx_b2b_done_cnt", txd_n - td0, 2);
        chk("tx_idle_line", {31'd0, out_uart_tx}, 1);

        // concurrent random RX and TX against the frame model
        expq.delete();
        q0 = rxq.size();
        f0 = ferr_n;
        fexp = 0;
        fork
            begin
                int tt;
                logic [7:0] rd;
                logic rs;
                for (int n = 0; n < 10; n++) begin
                    rd = 8'($urandom);
                    rs = ($urandom_range(0, 3) != 0);
                    if (rs) expq.push_back(rd);
                    else fexp++;
                    pulse_rx_trig();
                    host_send(rd, rs, tt);
                    repeat ($urandom_range(CPB, 3 * CPB)) @(negedge clk);
                end
            end
            begin
                for (int n = 0; n < 6; n++) send_tx(8'($urandom));
            end
        join
        repeat (2 * CPB) @(negedge clk);
        nexp = expq.size();
        chk("rand_rx_count", rxq.size() - q0, nexp);
        chk("rand_rx_ferr", ferr_n - f0, fexp);
        for (int n = 0; n < nexp; n++)
            if (q0 + n < rxq.size())
                chk($sformatf("rand_rx_data%0d", n), {24'd0, rxq[q0 + n]}, {24'd0, expq[n]});

        // buffering and overrun
        pulse_rx_trig();
        q0 = rxq.size();
        host_send(8'h11, 1'b1, t0);
        repeat (2 * CPB) @(negedge clk);
        chk("ovr_11_count", rxq.size() - q0, 1);
        if (rxq.size() > q0) chk("ovr_11_data", {24'd0, rxq[q0]}, 32'h11);
        host_send(8'h22, 1'b1, t0);
        repeat (2 * CPB) @(negedge clk);
        chk("ovr_22_held", rxq.size() - q0, 1);
        chk("ovr_pre_flag", {31'd0, out_rx_overrun}, 0);
        pulse_rx_trig();
        chk("ovr_22_done", {31'd0, rx_done}, 1);
        chk("ovr_22_data", {24'd0, data_rx}, 32'h22);
        @(negedge clk);
        chk("ovr_22_onepulse", {31'd0, rx_done}, 0);
        host_send(8'h44, 1'b1, t0);
        repeat (2 * CPB) @(negedge clk);
        host_send(8'h33, 1'b1, t0);
        repeat (2 * CPB) @(negedge clk);
        chk("ovr_flag", {31'd0, out_rx_overrun}, 1);
        chk("ovr_no_delivery", rxq.size() - q0, 2);
        pulse_rx_trig();
        chk("ovr_44_done", {31'd0, rx_done}, 1);
        chk("ovr_44_data", {24'd0, data_rx}, 32'h44);
        @(negedge clk);
        pulse_rx_trig();
        repeat (2 * CPB) @(negedge clk);
        chk("ovr_33_dropped", rxq.size() - q0, 3);
        chk("ovr_sticky", {31'd0, out_rx_overrun}, 1);

        // reset during TX data bit 3 and RX data bit 5
        q0 = rxq.size();
        f0 = ferr_n;
        td0 = txd_n;
        d = 8'h96;
        fr = {1'b1, d, 1'b0};
        for (int i = 0; i < 50; i++) begin
            in_uart_rx = fr[i / CPB];
            tx_trig = (i == 16);
            data_tx = 8'hA7;
            @(negedge clk);
        end
        chk("mid_busy", {31'd0, out_tx_busy}, 1);
        chk("mid_tx_bit3", {31'd0, out_uart_tx}, 0);
        in_rst = 1'b1;
        in_uart_rx = 1'b1;
        @(negedge clk);
        chk("abort_tx_line", {31'd0, out_uart_tx}, 1);
        chk("abort_busy", {31'd0, out_tx_busy}, 0);
        in_rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        chk("abort_no_txdone", txd_n - td0, 0);
        chk("abort_no_rxdone", rxq.size() - q0, 0);
        chk("abort_no_ferr", ferr_n - f0, 0);
        chk("abort_ovr_clear", {31'd0, out_rx_overrun}, 0);
        st = 1'b1;
        host_send(8'h5A, st, t0);
        repeat (2 * CPB) @(negedge clk);
        chk("after_rst_count", rxq.size() - q0, 1);
        if (rxq.size() > q0) chk("after_rst_data", {24'd0, rxq[q0]}, 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
